// File: rtl/simd_addsub_row_if.sv
// Row add/sub handshake bundle: input row (a/b/op), result row, and overflow flags.
// The slave modport is the arithmetic unit; the master side is the matrix controller.
interface simd_addsub_row_if #(
  parameter int LANES = 5,
  parameter int EW    = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [LANES*EW-1:0]   a;
  logic [LANES*EW-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*EW-1:0]   m_out;
  logic [LANES-1:0]      ovf_lane;
  logic                  ovf;
  logic                  ovf_sticky;
  logic                  clr_sticky;

  modport master (
    output in_valid, op, a, b, out_ready, clr_sticky,
    input  in_ready, out_valid, m_out, ovf_lane, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, op, a, b, out_ready, clr_sticky,
    output in_ready, out_valid, m_out, ovf_lane, ovf, ovf_sticky
  );
endinterface

// File: rtl/simd_addsub_row.sv
// Two-stage packed-lane add/sub/pass/neg unit with per-lane and sticky overflow flags.
// Build option SIMD_SAT_EN: overflowed lanes saturate instead of wrapping.

module simd_addsub_lane #(
  parameter int EW = 8
) (
  input  logic [1:0]  op,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW:0] raw,
  input  logic [EW:0] raw_q,
  output logic [EW-1:0] res,
  output logic        ovf
);
  logic [EW:0] ax, bx;

  assign ax = {a[EW-1], a};
  assign bx = {b[EW-1], b};

  always_comb begin
    raw = ax;
    case (op)
      2'b00:   raw = ax + bx;
      2'b01:   raw = ax - bx;
      2'b10:   raw = ax;
      default: raw = {(EW+1){1'b0}} - bx;
    endcase
  end

  // One guard bit is enough: the sign bit disagreeing with the guard means overflow.
  assign ovf = raw_q[EW] ^ raw_q[EW-1];

  always_comb begin
    res = raw_q[EW-1:0];
`ifdef SIMD_SAT_EN
    if (ovf) res = raw_q[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
`endif
  end
endmodule

module simd_addsub_row #(
  parameter int LANES = 5,
  parameter int EW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  simd_addsub_row_if.slave bus
);
  typedef struct packed {
    logic [LANES-1:0][EW-1:0] res;
    logic [LANES-1:0]         ovf;
  } s2_t;

  logic [2:1]               vld_pipe_q, vld_pipe_d;
  logic [LANES-1:0][EW:0]   raw_d, raw_q;
  logic [LANES-1:0][EW-1:0] res_c;
  logic [LANES-1:0]         ovf_c;
  s2_t                      s2_d, s2_q;
  logic                     sticky_d, sticky_q;
  logic                     s1_adv, s2_adv, in_fire, out_fire, ovf_any;

  assign s2_adv   = !vld_pipe_q[2] || bus.out_ready;
  assign s1_adv   = s2_adv || !vld_pipe_q[1];
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = vld_pipe_q[2] && bus.out_ready;
  assign ovf_any  = vld_pipe_q[2] && (|s2_q.ovf);

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      simd_addsub_lane #(.EW(EW)) u_lane (
        .op    (bus.op),
        .a     (bus.a[i*EW +: EW]),
        .b     (bus.b[i*EW +: EW]),
        .raw   (raw_d[i]),
        .raw_q (raw_q[i]),
        .res   (res_c[i]),
        .ovf   (ovf_c[i])
      );
    end
  endgenerate

  assign s2_d = '{res: res_c, ovf: ovf_c};

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (s1_adv) vld_pipe_d[1] = in_fire;
    if (s2_adv) vld_pipe_d[2] = vld_pipe_q[1];
  end

  // A setting transfer overrides a coincident clear.
  assign sticky_d = (bus.clr_sticky ? 1'b0 : sticky_q) | (out_fire && ovf_any);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      raw_q      <= '0;
      s2_q       <= '0;
      sticky_q   <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sticky_q   <= sticky_d;
      if (in_fire) raw_q <= raw_d;
      if (s2_adv && vld_pipe_q[1]) s2_q <= s2_d;
    end
  end

  assign bus.in_ready   = !vld_pipe_q[1] || s1_adv;
  assign bus.out_valid  = vld_pipe_q[2];
  assign bus.m_out      = s2_q.res;
  assign bus.ovf_lane   = s2_q.ovf;
  assign bus.ovf        = ovf_any;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_simd_addsub_row.sv
// Randomized bench for simd_addsub_row against an integer-arithmetic reference model,
// plus directed literal vectors for arithmetic, backpressure, sticky flag and reset.
module tb_simd_addsub_row;
  localparam int LANES = 5;
  localparam int EW    = 8;
  localparam int W     = LANES * EW;
  localparam int MAXV  = (1 << (EW - 1)) - 1;
  localparam int MINV  = -(1 << (EW - 1));

`ifdef SIMD_SAT_EN
  localparam logic [W-1:0] E_ADD = 40'h7F20E08002;
  localparam logic [W-1:0] E_SUB = 40'h0200000080;
  localparam logic [W-1:0] E_NEG = 40'hFF0000007F;
`else
  localparam logic [W-1:0] E_ADD = 40'h8020E07F02;
  localparam logic [W-1:0] E_SUB = 40'h020000007F;
  localparam logic [W-1:0] E_NEG = 40'hFF00000080;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_addsub_row_if #(.LANES(LANES), .EW(EW)) bus ();
  simd_addsub_row #(.LANES(LANES), .EW(EW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_out = 0;
  logic st_m = 1'b0;
  logic [W-1:0]     qm[$];
  logic [LANES-1:0] qo[$];
  int               qt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] m, output logic [LANES-1:0] o);
    m = '0;
    o = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [EW-1:0] sa, sb;
      int ai, bi, r;
      sa = a[i*EW +: EW];
      sb = b[i*EW +: EW];
      ai = sa;
      bi = sb;
      case (op)
        2'd0:    r = ai + bi;
        2'd1:    r = ai - bi;
        2'd2:    r = ai;
        default: r = -bi;
      endcase
      o[i] = (r > MAXV) || (r < MINV);
`ifdef SIMD_SAT_EN
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
`endif
      m[i*EW +: EW] = r[EW-1:0];
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    logic [EW-1:0] e;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0:       e = 8'h80;
        1:       e = 8'h7F;
        2:       e = 8'hFF;
        3:       e = 8'h00;
        default: e = EW'($urandom_range(0, 255));
      endcase
      v[i*EW +: EW] = e;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] bp_word(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*EW +: EW] = EW'(k * 16 + 3 + i);
    return v;
  endfunction

  // Reference monitor: words enter the model on input transfer and must appear
  // two edges later, in order, holding while stalled.
  initial begin
    logic ov_e, ir_e;
    logic [W-1:0] m;
    logic [LANES-1:0] o;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        qm.delete(); qo.delete(); qt.delete();
        st_m = 1'b0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_m_out", bus.m_out, '0);
        chk("rst_sticky", bus.ovf_sticky, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
      end else begin
        ov_e = (qm.size() > 0) && (cyc - qt[0] >= 2);
        ir_e = (qm.size() < 2) || bus.out_ready;
        chk("out_valid", bus.out_valid, ov_e);
        chk("in_ready", bus.in_ready, ir_e);
        chk("ovf_sticky", bus.ovf_sticky, st_m);
        if (bus.clr_sticky) st_m = 1'b0;
        if (ov_e) begin
          chk("m_out", bus.m_out, qm[0]);
          chk("ovf_lane", bus.ovf_lane, qo[0]);
          chk("ovf", bus.ovf, |qo[0]);
          if (bus.out_ready) begin
            if (|qo[0]) st_m = 1'b1;
            void'(qm.pop_front()); void'(qo.pop_front()); void'(qt.pop_front());
            n_out++;
          end
        end
        if (bus.in_valid && ir_e) begin
          model(bus.op, bus.a, bus.b, m, o);
          qm.push_back(m); qo.push_back(o); qt.push_back(cyc);
        end
      end
    end
  end

  task automatic lit_send(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] me, input logic [LANES-1:0] oe);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_m_out"}, bus.m_out, me);
    chk({nm, "_ovf_lane"}, bus.ovf_lane, oe);
    chk({nm, "_ovf"}, bus.ovf, |oe);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] m;
    logic [LANES-1:0] o;
    int idx, out0;
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model on the hand-worked ADD vector.
    model(2'b00, 40'h7F10F08001, 40'h0110F0FF01, m, o);
    chk("model_add_m", m, E_ADD);
    chk("model_add_o", o, 5'b10010);

    lit_send("add",  2'b00, 40'h7F10F08001, 40'h0110F0FF01, E_ADD, 5'b10010);
    lit_send("sub",  2'b01, 40'h0500000080, 40'h0300000001, E_SUB, 5'b00001);
    lit_send("neg",  2'b11, 40'h1122334455, 40'h0100000080, E_NEG, 5'b00001);
    lit_send("pass", 2'b10, 40'h807F0001FF, 40'h0180808080, 40'h807F0001FF, 5'b00000);

    // Backpressure: 4 words offered while the sink is stalled.
    @(posedge clk); #1;
    out0 = n_out;
    bus.out_ready = 1'b0;
    idx = 0;
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = bp_word(0); bus.b = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 4) bus.a = bp_word(idx); else bus.in_valid = 1'b0;
    end
    chk("bp_accepted", idx, 2);
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_hold_word0", bus.m_out, bp_word(0));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 4) bus.a = bp_word(idx); else bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && qm.size() != 0; c++) @(posedge clk);
    #1;
    chk("bp_all_out", n_out - out0, 4);

    // Randomized traffic with random stalls and occasional sticky clears.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.op         = 2'($urandom_range(0, 3));
      bus.a          = rand_word();
      bus.b          = rand_word();
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.clr_sticky = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_sticky = 1'b0;
    for (int c = 0; c < 20 && qm.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", qm.size(), 0);

    // Sticky flag directed sequence.
    @(posedge clk); #1 bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_cleared0", bus.ovf_sticky, 1'b0);
    lit_send("st_ovf", 2'b00, 40'h7F10F08001, 40'h0110F0FF01, E_ADD, 5'b10010);
    @(negedge clk);
    chk("sticky_set", bus.ovf_sticky, 1'b1);
    lit_send("st_clean", 2'b10, 40'h0102030405, 40'h0, 40'h0102030405, 5'b00000);
    @(negedge clk);
    chk("sticky_hold", bus.ovf_sticky, 1'b1);
    @(posedge clk); #1 bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_clr", bus.ovf_sticky, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.a = 40'h0000000080; bus.b = 40'h0000000001;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1 bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", bus.ovf_sticky, 1'b1);

    // Asynchronous reset with two words in flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.a = rand_word(); bus.b = rand_word();
    @(posedge clk); #1 bus.a = rand_word();
    @(posedge clk); #1 bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_m_out", bus.m_out, '0);
    chk("arst_sticky", bus.ovf_sticky, 1'b0);
    chk("arst_ovf", bus.ovf, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    chk("post_rst_no_stale", bus.out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
